// File: rtl/patch_pkg.sv
// Shared types and constants for the address-patch lookup table.
// The entry field widths set the upper bound for the AW/DW parameters of patch_table.
package patch_pkg;

  localparam int ENTRY_AW  = 32;
  localparam int ENTRY_DW  = 32;
  localparam int ENTRY_CW  = (ENTRY_AW > ENTRY_DW) ? ENTRY_AW : ENTRY_DW;
  localparam int HIT_CNT_W = 16;

  localparam logic [1:0] OFS_CTRL = 2'd0;
  localparam logic [1:0] OFS_ADDR = 2'd1;
  localparam logic [1:0] OFS_DATA = 2'd2;
  localparam logic [1:0] OFS_HITS = 2'd3;

  // The data field is config-width because its low AW bits also serve as the patch address.
  typedef struct packed {
    logic                valid;
    logic [ENTRY_AW-1:0] addr;
    logic [ENTRY_CW-1:0] data;
  } patch_entry_t;

  function automatic int max_w(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/patch_table_if.sv
// Config slave and lookup/result handshake bundle for patch_table.
// Signal suffixes are from the patch_table side: _i is driven into it, _o is driven by it.
interface patch_table_if #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int N_ENTRIES = 8
);
  localparam int CW = patch_pkg::max_w(AW, DW);
  localparam int IW = $clog2(N_ENTRIES);

  logic          cfg_cyc_i;
  logic          cfg_stb_i;
  logic          cfg_we_i;
  logic [IW+1:0] cfg_adr_i;
  logic [CW-1:0] cfg_dat_i;
  logic [CW-1:0] cfg_dat_o;
  logic          cfg_ack_o;

  logic          lk_valid_i;
  logic [AW-1:0] lk_addr_i;
  logic          lk_ready_o;

  logic          pm_valid_o;
  logic          pm_ready_i;
  logic          pm_match_o;
  logic [AW-1:0] pm_addr_o;
  logic [DW-1:0] pm_data_o;

  modport slave (
    input  cfg_cyc_i, cfg_stb_i, cfg_we_i, cfg_adr_i, cfg_dat_i,
    output cfg_dat_o, cfg_ack_o,
    input  lk_valid_i, lk_addr_i,
    output lk_ready_o,
    output pm_valid_o, pm_match_o, pm_addr_o, pm_data_o,
    input  pm_ready_i
  );

  modport master (
    output cfg_cyc_i, cfg_stb_i, cfg_we_i, cfg_adr_i, cfg_dat_i,
    input  cfg_dat_o, cfg_ack_o,
    output lk_valid_i, lk_addr_i,
    input  lk_ready_o,
    input  pm_valid_o, pm_match_o, pm_addr_o, pm_data_o,
    output pm_ready_i
  );

endinterface

// File: rtl/patch_prio_enc.sv
// Combinational priority encoder: N-bit hit vector to {any, index}, lowest index wins.
module patch_prio_enc #(
  parameter  int N  = 8,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  hit_i,
  output logic          any_o,
  output logic [IW-1:0] idx_o
);

  // Scanning downward lets the lowest set bit be the last (winning) assignment.
  always_comb begin
    any_o = |hit_i;
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (hit_i[i]) idx_o = IW'(i);
    end
  end

endmodule

// File: rtl/patch_table.sv
// Programmable address-patch lookup table with a single-beat config slave and a 1-stage result register.
// Optional per-entry saturating hit counters are enabled by defining PATCH_HIT_COUNT_EN.
module patch_table
  import patch_pkg::*;
#(
  parameter int AW        = ENTRY_AW,
  parameter int DW        = ENTRY_DW,
  parameter int N_ENTRIES = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  patch_table_if.slave bus
);

  localparam int CW = max_w(AW, DW);
  localparam int IW = $clog2(N_ENTRIES);

  patch_entry_t entry_q [N_ENTRIES];
  patch_entry_t entry_d [N_ENTRIES];

  logic [N_ENTRIES-1:0] hit_vec;
  logic                 hit_any;
  logic [IW-1:0]        hit_idx;

  logic          lk_ready;
  logic          lk_accept;
  logic          pm_valid_q, pm_valid_d;
  logic          pm_match_q, pm_match_d;
  logic [AW-1:0] pm_addr_q,  pm_addr_d;
  logic [DW-1:0] pm_data_q,  pm_data_d;

  logic          cfg_req;
  logic          cfg_wr;
  logic [IW-1:0] cfg_idx;
  logic [1:0]    cfg_ofs;
  logic [CW-1:0] rd_data;
  logic          ack_q, ack_d;
  logic [CW-1:0] cfg_dat_q, cfg_dat_d;

  // A request is only taken while no ack is outstanding, giving at most one ack per two cycles.
  assign cfg_idx = bus.cfg_adr_i[IW+1:2];
  assign cfg_ofs = bus.cfg_adr_i[1:0];
  assign cfg_req = bus.cfg_cyc_i & bus.cfg_stb_i & ~ack_q;
  assign cfg_wr  = cfg_req & bus.cfg_we_i;

  assign lk_ready  = ~pm_valid_q | bus.pm_ready_i;
  assign lk_accept = bus.lk_valid_i & lk_ready;

  // Matching reads the registered table, so a same-cycle config write is seen only by later lookups.
  always_comb begin
    for (int i = 0; i < N_ENTRIES; i++) begin
      hit_vec[i] = entry_q[i].valid && (entry_q[i].addr == ENTRY_AW'(bus.lk_addr_i));
    end
  end

  patch_prio_enc #(.N(N_ENTRIES)) u_prio_enc (
    .hit_i (hit_vec),
    .any_o (hit_any),
    .idx_o (hit_idx)
  );

`ifdef PATCH_HIT_COUNT_EN
  logic [HIT_CNT_W-1:0] hits_q [N_ENTRIES];
  logic [HIT_CNT_W-1:0] hits_d [N_ENTRIES];

  // A clear from the config port takes priority over a same-cycle count.
  always_comb begin
    for (int i = 0; i < N_ENTRIES; i++) begin
      hits_d[i] = hits_q[i];
      if (cfg_wr && (cfg_ofs == OFS_HITS) && (cfg_idx == IW'(i))) begin
        hits_d[i] = '0;
      end else if (lk_accept && hit_any && (hit_idx == IW'(i)) && (hits_q[i] != '1)) begin
        hits_d[i] = hits_q[i] + HIT_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_ENTRIES; i++) hits_q[i] <= '0;
    end else begin
      hits_q <= hits_d;
    end
  end
`endif

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    for (int i = 0; i < N_ENTRIES; i++) entry_d[i] = entry_q[i];
    if (cfg_wr) begin
      case (cfg_ofs)
        OFS_CTRL: entry_d[cfg_idx].valid = bus.cfg_dat_i[0];
        OFS_ADDR: entry_d[cfg_idx].addr  = ENTRY_AW'(bus.cfg_dat_i[AW-1:0]);
        OFS_DATA: entry_d[cfg_idx].data  = ENTRY_CW'(bus.cfg_dat_i);
        default:  ;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    case (cfg_ofs)
      OFS_CTRL: rd_data[0] = entry_q[cfg_idx].valid;
      OFS_ADDR: rd_data    = CW'(entry_q[cfg_idx].addr);
      OFS_DATA: rd_data    = CW'(entry_q[cfg_idx].data);
`ifdef PATCH_HIT_COUNT_EN
      OFS_HITS: rd_data    = CW'(hits_q[cfg_idx]);
`endif
      default:  ;
    endcase
    ack_d     = cfg_req;
    cfg_dat_d = (cfg_req && !bus.cfg_we_i) ? rd_data : '0;
  end

  // The result register advances whenever it is empty or being drained; otherwise it holds.
  always_comb begin
    pm_valid_d = pm_valid_q;
    pm_match_d = pm_match_q;
    pm_addr_d  = pm_addr_q;
    pm_data_d  = pm_data_q;
    if (lk_ready) begin
      pm_valid_d = bus.lk_valid_i;
      if (bus.lk_valid_i) begin
        pm_match_d = hit_any;
        pm_addr_d  = hit_any ? entry_q[hit_idx].data[AW-1:0] : bus.lk_addr_i;
        pm_data_d  = hit_any ? entry_q[hit_idx].data[DW-1:0] : '0;
      end
    end
  end

  // NOTE: the table is flop-based and reset explicitly, since entries must come up invalid.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_ENTRIES; i++) entry_q[i] <= '0;
      ack_q      <= 1'b0;
      cfg_dat_q  <= '0;
      pm_valid_q <= 1'b0;
      pm_match_q <= 1'b0;
      pm_addr_q  <= '0;
      pm_data_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge state.
      entry_q    <= entry_d;
      ack_q      <= ack_d;
      cfg_dat_q  <= cfg_dat_d;
      pm_valid_q <= pm_valid_d;
      pm_match_q <= pm_match_d;
      pm_addr_q  <= pm_addr_d;
      pm_data_q  <= pm_data_d;
    end
  end

  assign bus.lk_ready_o = lk_ready;
  assign bus.pm_valid_o = pm_valid_q;
  assign bus.pm_match_o = pm_match_q;
  assign bus.pm_addr_o  = pm_addr_q;
  assign bus.pm_data_o  = pm_data_q;
  assign bus.cfg_ack_o  = ack_q;
  assign bus.cfg_dat_o  = cfg_dat_q;

endmodule
